// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle control path: opcodes, FSM states,
// instruction classes and the datapath select encodings.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_IMM, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILLEGAL
  } cls_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_FUNCT = 2'd1;
  localparam logic [1:0] ALU_CMP   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class, immediate-format select, legality.
module ctrl_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_e       cls_o,
  output logic [6:0] imm_sel_o,
  output logic       legal_o
);

  always_comb begin
    cls_o     = CL_ILLEGAL;
    imm_sel_o = opcode_i;
    legal_o   = 1'b1;
    unique case (opcode_i)
      OP_R:      begin cls_o = CL_R; imm_sel_o = '0; end
      OP_IMM:    cls_o = CL_IMM;
      OP_LOAD:   cls_o = CL_LOAD;
      OP_STORE:  cls_o = CL_STORE;
      OP_BRANCH: cls_o = CL_BRANCH;
      OP_JAL:    cls_o = CL_JAL;
      OP_JALR:   begin cls_o = CL_JALR;  imm_sel_o = OP_IMM; end
      OP_LUI:    cls_o = CL_LUI;
      OP_AUIPC:  begin cls_o = CL_AUIPC; imm_sel_o = OP_LUI; end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-timeout and
// illegal-opcode halting. Outputs are decoded from state and forced low during reset.
module core_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic [6:0]  imm_sel_out,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        bus_err_out,
  output logic        illegal_out
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       illegal_q, illegal_d;

  cls_e       cls;
  logic [6:0] dec_imm;
  logic       dec_legal;
  logic       unused_instr;

  assign unused_instr = ^instr_in[31:7];

  ctrl_decode u_decode (
    .opcode_i  (instr_in[6:0]),
    .cls_o     (cls),
    .imm_sel_o (dec_imm),
    .legal_o   (dec_legal)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    bus_err_d    = bus_err_q;
    illegal_d    = illegal_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    ir_we        = 1'b0;
    imm_sel_out  = '0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;

    // ALU selects stay valid through MEM and WB: the datapath uses the ALU
    // result as the memory address and as the JALR target there.
    if (rst_n && (state_q inside {ST_EXEC, ST_MEM, ST_WB})) begin
      imm_sel_out = dec_imm;
      unique case (cls)
        CL_R:                       alu_op = ALU_FUNCT;
        CL_IMM:                     begin alu_src_b = 1'b1; alu_op = ALU_FUNCT; end
        CL_LOAD, CL_STORE, CL_JALR: alu_src_b = 1'b1;
        CL_AUIPC:                   begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
        CL_BRANCH:                  alu_op = ALU_CMP;
        default: ;
      endcase
    end

    if (rst_n) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_req      = 1'b1;
          mem_is_fetch = 1'b1;
          ir_we        = mem_ack;
          if (mem_ack) state_d = ST_DECODE;
        end
        ST_DECODE: begin
          imm_sel_out = dec_imm;
          if (dec_legal) begin
            state_d = ST_EXEC;
          end else begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        end
        ST_EXEC: begin
          unique case (cls)
            CL_BRANCH: begin
              pc_we   = 1'b1;
              pc_src  = br_taken ? PC_IMM : PC_PLUS4;
              state_d = ST_FETCH;
            end
            CL_LOAD, CL_STORE: state_d = ST_MEM;
            default:           state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == CL_STORE);
          if (mem_ack) begin
            if (cls == CL_STORE) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
          unique case (cls)
            CL_JAL:  begin wb_sel = WB_PC4; pc_src = PC_IMM; end
            CL_JALR: begin wb_sel = WB_PC4; pc_src = PC_ALU; end
            CL_LOAD: wb_sel = WB_MEM;
            CL_LUI:  wb_sel = WB_IMM;
            default: ;
          endcase
        end
        default: ;
      endcase

      // Ack wins over a simultaneous timeout.
      if (mem_req && !mem_ack) begin
        if (wait_q == WAIT_LAST) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus_err_out = bus_err_q;
  assign illegal_out = illegal_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed per-cycle vector bench for core_ctrl (MEM_TIMEOUT = 4).
module tb_core_ctrl;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       fe;
    logic       ir;
    logic [6:0] imm;
    logic       a;
    logic       b;
    logic [1:0] op;
    logic       rf;
    logic [1:0] wb;
    logic       pw;
    logic [1:0] ps;
    logic       berr;
    logic       ill;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        ack;
    logic        br;
    out_t        exp;
  } vec_t;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h00002083;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_SW    = 32'h00102023;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in = '0;
  logic        mem_ack = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, mem_is_fetch, ir_we;
  logic [6:0]  imm_sel_out;
  logic        alu_src_a, alu_src_b, rf_we, pc_we, bus_err_out, illegal_out;
  logic [1:0]  alu_op, wb_sel, pc_src;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];

  core_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .mem_ack(mem_ack),
    .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .imm_sel_out(imm_sel_out),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
    .bus_err_out(bus_err_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(input logic req, input logic we, input logic fe,
                              input logic ir, input logic [6:0] imm,
                              input logic a, input logic b, input logic [1:0] op,
                              input logic rf, input logic [1:0] wb,
                              input logic pw, input logic [1:0] ps);
    out_t o;
    o.req = req; o.we = we; o.fe = fe; o.ir = ir; o.imm = imm;
    o.a = a; o.b = b; o.op = op; o.rf = rf; o.wb = wb; o.pw = pw; o.ps = ps;
    o.berr = 1'b0; o.ill = 1'b0;
    return o;
  endfunction

  function automatic out_t F(input logic ack);
    return mk(1, 0, 1, ack, 7'h00, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
  endfunction

  function automatic out_t D(input logic [6:0] imm);
    return mk(0, 0, 0, 0, imm, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
  endfunction

  function automatic out_t Z(input logic berr, input logic ill);
    out_t o;
    o = '0;
    o.berr = berr;
    o.ill = ill;
    return o;
  endfunction

  task automatic add(input logic [31:0] instr, input logic ack, input logic br, input out_t e);
    vec_t v;
    v.instr = instr; v.ack = ack; v.br = br; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input out_t e);
    out_t act;
    act = {mem_req, mem_we, mem_is_fetch, ir_we, imm_sel_out, alu_src_a, alu_src_b,
           alu_op, rf_we, wb_sel, pc_we, pc_src, bus_err_out, illegal_out};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %06h expected %06h", name, act, e);
    end
  endtask

  task automatic step(input string name, input logic [31:0] instr, input logic ack,
                      input logic br, input out_t e);
    instr_in = instr; mem_ack = ack; br_taken = br;
    #2;
    check(name, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #2;
    check("reset_zero", Z(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ADDI
    add(I_ADDI, 1, 0, F(1));
    add(I_ADDI, 0, 0, D(7'h13));
    add(I_ADDI, 0, 0, mk(0, 0, 0, 0, 7'h13, 0, 1, 2'd1, 0, 2'd0, 0, 2'd0));
    add(I_ADDI, 0, 0, mk(0, 0, 0, 0, 7'h13, 0, 1, 2'd1, 1, 2'd0, 1, 2'd0));
    // LW, ack on 4th MEM cycle (equals the timeout boundary)
    add(I_LW, 1, 0, F(1));
    add(I_LW, 0, 0, D(7'h03));
    add(I_LW, 0, 0, mk(0, 0, 0, 0, 7'h03, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    for (int i = 0; i < 3; i++)
      add(I_LW, 0, 0, mk(1, 0, 0, 0, 7'h03, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    add(I_LW, 1, 0, mk(1, 0, 0, 0, 7'h03, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    add(I_LW, 0, 0, mk(0, 0, 0, 0, 7'h03, 0, 1, 2'd0, 1, 2'd1, 1, 2'd0));
    // BEQ taken, then not taken
    add(I_BEQ, 1, 0, F(1));
    add(I_BEQ, 0, 0, D(7'h63));
    add(I_BEQ, 0, 1, mk(0, 0, 0, 0, 7'h63, 0, 0, 2'd2, 0, 2'd0, 1, 2'd1));
    add(I_BEQ, 1, 0, F(1));
    add(I_BEQ, 0, 0, D(7'h63));
    add(I_BEQ, 0, 0, mk(0, 0, 0, 0, 7'h63, 0, 0, 2'd2, 0, 2'd0, 1, 2'd0));
    // JALR
    add(I_JALR, 1, 0, F(1));
    add(I_JALR, 0, 0, D(7'h13));
    add(I_JALR, 0, 0, mk(0, 0, 0, 0, 7'h13, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    add(I_JALR, 0, 0, mk(0, 0, 0, 0, 7'h13, 0, 1, 2'd0, 1, 2'd2, 1, 2'd2));
    // SW, zero-wait
    add(I_SW, 1, 0, F(1));
    add(I_SW, 0, 0, D(7'h23));
    add(I_SW, 0, 0, mk(0, 0, 0, 0, 7'h23, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    add(I_SW, 1, 0, mk(1, 1, 0, 0, 7'h23, 0, 1, 2'd0, 0, 2'd0, 1, 2'd0));
    // LUI
    add(I_LUI, 1, 0, F(1));
    add(I_LUI, 0, 0, D(7'h37));
    add(I_LUI, 0, 0, D(7'h37));
    add(I_LUI, 0, 0, mk(0, 0, 0, 0, 7'h37, 0, 0, 2'd0, 1, 2'd3, 1, 2'd0));
    // AUIPC
    add(I_AUIPC, 1, 0, F(1));
    add(I_AUIPC, 0, 0, D(7'h37));
    add(I_AUIPC, 0, 0, mk(0, 0, 0, 0, 7'h37, 1, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    add(I_AUIPC, 0, 0, mk(0, 0, 0, 0, 7'h37, 1, 1, 2'd0, 1, 2'd0, 1, 2'd0));
    // JAL
    add(I_JAL, 1, 0, F(1));
    add(I_JAL, 0, 0, D(7'h6F));
    add(I_JAL, 0, 0, D(7'h6F));
    add(I_JAL, 0, 0, mk(0, 0, 0, 0, 7'h6F, 0, 0, 2'd0, 1, 2'd2, 1, 2'd1));
    // ADD with a two-cycle fetch wait
    add(I_ADD, 0, 0, F(0));
    add(I_ADD, 0, 0, F(0));
    add(I_ADD, 1, 0, F(1));
    add(I_ADD, 0, 0, D(7'h00));
    add(I_ADD, 0, 0, mk(0, 0, 0, 0, 7'h00, 0, 0, 2'd1, 0, 2'd0, 0, 2'd0));
    add(I_ADD, 0, 0, mk(0, 0, 0, 0, 7'h00, 0, 0, 2'd1, 1, 2'd0, 1, 2'd0));
    // Illegal opcode halts; ack is ignored afterwards
    add(I_ILL, 1, 0, F(1));
    add(I_ILL, 0, 0, D(7'h7F));
    for (int i = 0; i < 3; i++) add(I_ILL, 1, 0, Z(0, 1));

    #2;
    check("reset_zero", Z(0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].instr, tbl[i].ack, tbl[i].br, tbl[i].exp);

    // Fetch timeout: four waiting cycles then HALT with bus error
    do_reset();
    for (int i = 0; i < 4; i++) step("timeout_wait", I_ADDI, 0, 0, F(0));
    step("timeout_halt", I_ADDI, 0, 0, Z(1, 0));
    step("timeout_stay", I_ADDI, 1, 0, Z(1, 0));

    // Ack on the 4th fetch cycle succeeds
    do_reset();
    for (int i = 0; i < 3; i++) step("late_ack_wait", I_ADDI, 0, 0, F(0));
    step("late_ack_fetch", I_ADDI, 1, 0, F(1));
    step("late_ack_decode", I_ADDI, 0, 0, D(7'h13));

    // Asynchronous reset in the middle of a MEM wait
    do_reset();
    step("mid_f", I_LW, 1, 0, F(1));
    step("mid_d", I_LW, 0, 0, D(7'h03));
    step("mid_e", I_LW, 0, 0, mk(0, 0, 0, 0, 7'h03, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    mem_ack = 1'b0;
    #2;
    check("mid_mem", mk(1, 0, 0, 0, 7'h03, 0, 1, 2'd0, 0, 2'd0, 0, 2'd0));
    #1 rst_n = 1'b0;
    #1 check("mid_reset", Z(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step("first_req", I_LW, 0, 0, F(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle control unit for the RV32I core. Sequences every instruction through fetch, decode, execute, memory and write-back. Drives the immediate generator's opcode select, ALU operand/operation selects, PC and register-file write enables, and the single shared memory port's request/acknowledge handshake. It sits between the instruction register and the datapath, and is the only block that changes architectural state enables.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum cycles a memory request waits for mem_ack before a bus error (1..255).

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_in  in  32  instruction register contents; stable from the cycle after fetch ack
- mem_ack  in  1  memory completion; may be high in the same cycle as mem_req
- br_taken  in  1  branch-compare result from ALU, valid in EXEC
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store, 0 = read; valid while mem_req
- mem_is_fetch  out  1  request is an instruction fetch
- ir_we  out  1  latch fetched word into instruction register
- imm_sel_out  out  7  opcode presented to immediate generator
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  0 ADD, 1 FUNCT (funct3/funct7 decode), 2 CMP (branch)
- rf_we  out  1  register-file write enable
- wb_sel  out  2  0 ALU, 1 memory data, 2 PC+4, 3 immediate
- pc_we  out  1  PC write enable
- pc_src  out  2  0 PC+4, 1 PC+imm, 2 ALU result with bit 0 cleared
- bus_err_out  out  1  sticky, memory timeout
- illegal_out  out  1  sticky, unsupported opcode

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH. All outputs are 0 at reset; imm_sel_out resets to 7'b0.
- FETCH: mem_req=1, mem_is_fetch=1, mem_we=0. ir_we = mem_ack. On ack, go to DECODE.
- DECODE: decode instr_in[6:0].
  - Supported: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: go to HALT and set illegal_out.
- imm_sel_out from DECODE until the instruction ends:
  - JALR (1100111) maps to 0010011 (I-format).
  - AUIPC (0010111) maps to 0110111 (U-format).
  - R-type maps to 0.
  - All other opcodes pass through unchanged.
  - imm_sel_out is 0 in FETCH.
- EXEC:
  - OP-IMM, load, store, JALR: alu_src_b=1.
  - Loads and stores use alu_op=ADD.
  - R/OP-IMM use FUNCT.
  - AUIPC: alu_src_a=1, alu_src_b=1, ADD.
  - Branch: alu_op=CMP, pc_we=1, pc_src = br_taken ? 1 : 0. Then go to FETCH.
- MEM (load/store only): mem_req=1, mem_we = store. Hold until ack.
  - Load then goes to WB.
  - Store asserts pc_we, pc_src=0 on the ack cycle, then goes to FETCH.
- WB: rf_we=1. wb_sel is 2 for JAL/JALR, 1 for load, 3 for LUI, otherwise 0. pc_we=1 in the same cycle:
  - pc_src=1 for JAL.
  - pc_src=2 for JALR.
  - pc_src=0 otherwise.
  - The register file and PC update on the same edge, so rd receives the old PC+4.
- Exactly one pc_we pulse per retired instruction. pc_we and rf_we are never asserted in FETCH or DECODE.
- Timeout:
  - An 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 without ack.
  - Reaching MEM_TIMEOUT goes to HALT, sets bus_err_out, and drops mem_req.
- HALT: all enables 0. Exit only through reset.

## Timing
- Zero-wait memory (ack with req), cycles per instruction:
  - Branch: 3.
  - R/OP-IMM/LUI/AUIPC/JAL/JALR: 4.
  - Store: 4.
  - Load: 5.
- Each cycle of ack delay adds one cycle to FETCH or MEM.
- mem_req, mem_we and mem_is_fetch are Moore outputs. ir_we follows mem_ack combinationally in FETCH only.
- Ack arriving in the same cycle the counter hits MEM_TIMEOUT counts as success; ack has priority.
- Reset asserted mid-instruction asynchronously forces FETCH and zeroes all outputs. This includes mem_req, so an in-flight request is abandoned.
- First mem_req is asserted in the first cycle after rst_n deasserts.

## Structure
- Package core_pkg holds:
  - Opcode constants, shared with the immediate generator.
  - The state enum.
  - The alu_op, wb_sel and pc_src encodings.
- Sub-module ctrl_decode: combinational opcode-to-control-class decode (instruction class, imm_sel mapping, legal flag). core_ctrl owns the FSM, the wait counter and the sticky flags.

## Test plan
- Zero-wait ADDI 0x00500093 → states F,D,E,W. WB cycle has rf_we=1, wb_sel=0, pc_we=1, pc_src=0. imm_sel_out=0010011 from DECODE.
- LW with ack delayed 3 cycles in MEM → mem_req high 4 cycles with mem_we=0, mem_is_fetch=0. Total 8 cycles. WB has wb_sel=1.
- BEQ with br_taken=1, then br_taken=0 → retires in 3 cycles. pc_src=1, then 0. rf_we never asserted.
- JALR 0x000080E7 → imm_sel_out=0010011. WB has rf_we=1, wb_sel=2, pc_we=1, pc_src=2.
- Opcode 1111111 → HALT after DECODE, illegal_out=1. No further mem_req until rst_n pulse.
- MEM_TIMEOUT=4 with mem_ack held low in FETCH → bus_err_out=1 after 4 cycles and mem_req drops. Repeat with ack on the 4th cycle → no error. Assert rst_n=0 mid-MEM → mem_req=0 immediately.
